// File: rtl/factorial_core.sv
`default_nettype none
// ============================================================================
// factorial_core : iterative n! engine (one compare, one multiply per step)
// Revision       : 1.0
// ============================================================================
module factorial_core #(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int MAX_N      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [N_WIDTH-1:0]    n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_MULT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N_WIDTH-1:0] MAX_N_V = N_WIDTH'(MAX_N);

  state_t                state_q, state_d;
  logic [N_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] cnt_ext;
  logic [DATA_WIDTH-1:0] mult_lo;

  // Only the low half of prod*cnt is ever kept, so a DATA_WIDTH multiply suffices.
  assign cnt_ext = {{(DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};
  assign mult_lo = prod_q * cnt_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          if (n > MAX_N_V) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d = S_CHECK;
            cnt_d   = n;
            prod_d  = DATA_WIDTH'(1);
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      S_CHECK: begin
        if (cnt_q > N_WIDTH'(1)) begin
          state_d = S_MULT;
        end else begin
          state_d  = S_DONE;
          result_d = prod_q;
          done_d   = 1'b1;
        end
      end
      S_MULT: begin
        prod_d  = mult_lo;
        cnt_d   = cnt_q - N_WIDTH'(1);
        state_d = S_CHECK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_CHECK) || (state_q == S_MULT);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_factorial_core.sv
`default_nettype none
// Self-checking bench for factorial_core: vector table, corner sequences, random ops vs model.
module tb_factorial_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go  = 1'b0;
  logic [3:0]  n   = 4'd0;
  logic        busy, done, err;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int edge_ctr = 0;

  factorial_core #(.DATA_WIDTH(32), .N_WIDTH(4), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .busy(busy), .done(done), .err(err), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_ctr <= edge_ctr + 1;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: factorial by plain arithmetic, latency from the step-count rule.
  task automatic model(input int nv, output logic [31:0] r, output logic e, output int lat);
    longint f = 1;
    if (nv > 12) begin
      r = 0; e = 1'b1; lat = 0;
    end else begin
      for (int i = 2; i <= nv; i++) f = f * i;
      r = f[31:0]; e = 1'b0;
      lat = (nv <= 1) ? 1 : 2 * nv - 1;
    end
  endtask

  // Call just after a negedge. Issues go for one cycle, then waits for done.
  task automatic run_op(input logic [3:0] nv, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat, input string nm);
    logic [31:0] prev;
    int base, busy_cnt, lat;
    prev = result;
    base = edge_ctr;
    go = 1'b1; n = nv;
    @(negedge clk);
    go = 1'b0; n = 4'($urandom);
    if (exp_lat == 0) begin
      chk({nm, " e0 done"}, 32'(done), 32'd1);
      chk({nm, " e0 err"}, 32'(err), 32'd1);
      chk({nm, " e0 result"}, result, 32'd0);
      chk({nm, " e0 busy"}, 32'(busy), 32'd0);
    end else begin
      chk({nm, " e0 done"}, 32'(done), 32'd0);
      chk({nm, " e0 err"}, 32'(err), 32'd0);
      chk({nm, " e0 result held"}, result, prev);
      chk({nm, " e0 busy"}, 32'(busy), 32'd1);
    end
    busy_cnt = 0;
    while (!done && (edge_ctr - base - 1) < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    lat = edge_ctr - base - 1;
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " result"}, result, exp_res);
    chk({nm, " err"}, 32'(err), 32'(exp_err));
    chk({nm, " busy at done"}, 32'(busy), 32'd0);
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
  endtask

  initial begin
    vec_t vecs[7];
    logic [31:0] r;
    logic        e;
    int          lat, base, dcnt, consec;
    logic        prevd;

    vecs[0] = '{4'd5,  32'd120,       1'b0, 9};
    vecs[1] = '{4'd0,  32'd1,         1'b0, 1};
    vecs[2] = '{4'd1,  32'd1,         1'b0, 1};
    vecs[3] = '{4'd12, 32'h1C8CFC00,  1'b0, 23};
    vecs[4] = '{4'd13, 32'd0,         1'b1, 0};
    vecs[5] = '{4'd15, 32'd0,         1'b1, 0};
    vecs[6] = '{4'd3,  32'd6,         1'b0, 5};

    #2 rst = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].n, vecs[i].res, vecs[i].err, vecs[i].lat, $sformatf("vec%0d n=%0d", i, vecs[i].n));
      if (i == 0) begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          chk($sformatf("hold%0d", k), {result[29:0], done, err}, {30'd120, 1'b1, 1'b0});
        end
      end
    end

    // go while busy is ignored
    base = edge_ctr;
    go = 1'b1; n = 4'd7;
    @(negedge clk);
    go = 1'b0; n = 4'($urandom);
    repeat (3) @(negedge clk);
    go = 1'b1; n = 4'd2;
    @(negedge clk);
    go = 1'b0;
    chk("ignored go busy", 32'(busy), 32'd1);
    while (!done && (edge_ctr - base - 1) < 40) @(negedge clk);
    chk("ignored go latency", 32'(edge_ctr - base - 1), 32'd13);
    chk("ignored go result", result, 32'd5040);

    // asynchronous reset mid-operation
    base = edge_ctr;
    go = 1'b1; n = 4'd9;
    @(negedge clk);
    go = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    chk("midrst result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(4'd4, 32'd24, 1'b0, 7, "post-reset n=4");

    // go held high: restart each DONE cycle, done pulses once per run
    go = 1'b1; n = 4'd2;
    dcnt = 0; consec = 0; prevd = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (done && prevd) consec++;
      prevd = done;
    end
    go = 1'b0;
    chk("held go done pulses", 32'(dcnt), 32'd4);
    chk("held go consecutive done", 32'(consec), 32'd0);
    chk("held go final result", result, 32'd2);
    @(negedge clk);

    // randomized operands against the reference model
    for (int i = 0; i < 25; i++) begin
      logic [3:0] nv;
      nv = 4'($urandom_range(0, 15));
      model(int'(nv), r, e, lat);
      run_op(nv, r, e, lat, $sformatf("rand%0d n=%0d", i, nv));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
